fixed_hardtanh_backward: RTL and testbench

FIXED_HARDTANH_BACKWARD -- requirements
Module: fixed_hardtanh_backward

---
 rtl/fixed_hardtanh_backward_pkg.sv | 22 ++
 rtl/hardtanh_mask_fifo.sv | 58 +++++
 rtl/fixed_hardtanh_backward.sv | 96 +++++++++
 tb/tb_fixed_hardtanh_backward.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_hardtanh_backward_pkg.sv
// Shared activation helpers: hardtanh clamp and pass-through mask for its gradient.
// Bounds and operands are raw fixed-point integers, sign-extended to 32 bits.
package fixed_hardtanh_backward_pkg;

  // One bit per lane: 1 when the forward value sat strictly inside the bounds.
  typedef logic mask_lane_t;

  function automatic logic signed [31:0] hardtanh_clamp(input logic signed [31:0] x,
                                                        input logic signed [31:0] lo,
                                                        input logic signed [31:0] hi);
    if (x <= lo) return lo;
    if (x >= hi) return hi;
    return x;
  endfunction

  function automatic mask_lane_t hardtanh_pass(input logic signed [31:0] x,
                                               input logic signed [31:0] lo,
                                               input logic signed [31:0] hi);
    return (x > lo) && (x < hi);
  endfunction

endpackage

// File: rtl/hardtanh_mask_fifo.sv
// Mask FIFO of any depth >= 2; read data is a registered entry, so a push is poppable next cycle.
// Pushes while full and pops while empty are ignored, so callers may present requests freely.
module hardtanh_mask_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_dat,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_dat,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_next(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fixed_hardtanh_backward.sv
// Hardtanh forward clamp (combinational) paired with its gradient gate (1-cycle registered output).
// Forward input stalls when the mask FIFO is full; gradients stall while it is empty or output is blocked.
module fixed_hardtanh_backward
  import fixed_hardtanh_backward_pkg::*;
#(
  parameter int MAX_VAL                     = 127,
  parameter int MIN_VAL                     = -128,
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int GRAD_PRECISION_0            = 8,
  parameter int MASK_DEPTH                  = 16,
  parameter int N = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]     data_in_0 [N-1:0],
  input  logic                                 data_in_0_valid,
  output logic                                 data_in_0_ready,
  output logic [DATA_IN_0_PRECISION_0-1:0]     data_out_0 [N-1:0],
  output logic                                 data_out_0_valid,
  input  logic                                 data_out_0_ready,
  input  logic [GRAD_PRECISION_0-1:0]          grad_in_0 [N-1:0],
  input  logic                                 grad_in_0_valid,
  output logic                                 grad_in_0_ready,
  output logic [GRAD_PRECISION_0-1:0]          grad_out_0 [N-1:0],
  output logic                                 grad_out_0_valid,
  input  logic                                 grad_out_0_ready,
  output logic [$clog2(MASK_DEPTH+1)-1:0]      mask_count
);

  if (MIN_VAL >= MAX_VAL) begin : g_bad_bounds
    $error("fixed_hardtanh_backward: MIN_VAL must be below MAX_VAL");
  end
  if (MASK_DEPTH < 2) begin : g_bad_depth
    $error("fixed_hardtanh_backward: MASK_DEPTH must be at least 2");
  end
  // Bounds are in raw fixed-point units, so the fraction width only needs to be sane.
  if (DATA_IN_0_PRECISION_1 >= DATA_IN_0_PRECISION_0) begin : g_bad_frac
    $error("fixed_hardtanh_backward: fraction width must be below total width");
  end

  mask_lane_t [N-1:0] push_mask;
  logic [N-1:0]       pop_mask;
  logic               fifo_full;
  logic               fifo_empty;
  logic               full_eff;
  logic               empty_eff;
  logic               fwd_xfer;
  logic               grad_xfer;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [31:0] x;
    assign x             = 32'($signed(data_in_0[i]));
    assign data_out_0[i] = DATA_IN_0_PRECISION_0'(hardtanh_clamp(x, MIN_VAL, MAX_VAL));
    assign push_mask[i]  = hardtanh_pass(x, MIN_VAL, MAX_VAL);
  end

  // Reset cycles present the FIFO as empty so nothing is pushed, popped or blocked on stale state.
  assign full_eff         = fifo_full && !rst;
  assign empty_eff        = fifo_empty || rst;
  assign data_out_0_valid = data_in_0_valid && !full_eff;
  assign data_in_0_ready  = data_out_0_ready && !full_eff;
  assign grad_in_0_ready  = !empty_eff && (!grad_out_0_valid || grad_out_0_ready);
  assign fwd_xfer         = data_in_0_valid && data_in_0_ready && !rst;
  assign grad_xfer        = grad_in_0_valid && grad_in_0_ready;

  hardtanh_mask_fifo #(
    .WIDTH (N),
    .DEPTH (MASK_DEPTH)
  ) u_mask_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fwd_xfer),
    .push_dat (push_mask),
    .pop      (grad_xfer),
    .pop_dat  (pop_mask),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (mask_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      grad_out_0_valid <= 1'b0;
      for (int i = 0; i < N; i++) grad_out_0[i] <= '0;
    end else if (grad_xfer) begin
      grad_out_0_valid <= 1'b1;
      for (int i = 0; i < N; i++) grad_out_0[i] <= pop_mask[i] ? grad_in_0[i] : '0;
    end else if (grad_out_0_ready) begin
      grad_out_0_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fixed_hardtanh_backward.sv
// Randomised and directed traffic against a queue-based hardtanh gradient model with a decoupled scoreboard.
module tb_fixed_hardtanh_backward;

  localparam int N = 4, W = 8, GW = 8, D = 16, MINV = -64, MAXV = 63;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  data_in_0 [N-1:0];
  logic          data_in_0_valid;
  logic          data_in_0_ready;
  logic [W-1:0]  data_out_0 [N-1:0];
  logic          data_out_0_valid;
  logic          data_out_0_ready;
  logic [GW-1:0] grad_in_0 [N-1:0];
  logic          grad_in_0_valid;
  logic          grad_in_0_ready;
  logic [GW-1:0] grad_out_0 [N-1:0];
  logic          grad_out_0_valid;
  logic          grad_out_0_ready;
  logic [CW-1:0] mask_count;

  always #5 clk = ~clk;

  fixed_hardtanh_backward #(
    .MAX_VAL(MAXV), .MIN_VAL(MINV),
    .DATA_IN_0_PRECISION_0(W), .DATA_IN_0_PRECISION_1(1),
    .DATA_IN_0_PARALLELISM_DIM_0(N), .DATA_IN_0_PARALLELISM_DIM_1(1),
    .GRAD_PRECISION_0(GW), .MASK_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in_0(data_in_0), .data_in_0_valid(data_in_0_valid), .data_in_0_ready(data_in_0_ready),
    .data_out_0(data_out_0), .data_out_0_valid(data_out_0_valid), .data_out_0_ready(data_out_0_ready),
    .grad_in_0(grad_in_0), .grad_in_0_valid(grad_in_0_valid), .grad_in_0_ready(grad_in_0_ready),
    .grad_out_0(grad_out_0), .grad_out_0_valid(grad_out_0_valid), .grad_out_0_ready(grad_out_0_ready),
    .mask_count(mask_count)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int clamp_ref(input int x);
    if (x <= MINV) return MINV;
    if (x >= MAXV) return MAXV;
    return x;
  endfunction

  // Reference model: a queue of masks plus a queue of expected gradient vectors.
  bit [N-1:0]        mask_q[$];
  bit [N*GW-1:0]     exp_q[$];
  bit                m_gv = 1'b0;
  bit                m_fwd, m_grad;
  bit [N-1:0]        m_mask;
  bit [N*GW-1:0]     m_exp;

  always @(posedge clk) begin
    if (rst) begin
      mask_q.delete();
      exp_q.delete();
      m_gv = 1'b0;
    end else begin
      m_fwd  = data_in_0_valid && data_out_0_ready && (mask_q.size() < D);
      m_grad = grad_in_0_valid && (mask_q.size() > 0) && (!m_gv || grad_out_0_ready);
      if (m_grad) begin
        m_mask = mask_q.pop_front();
        for (int i = 0; i < N; i++) m_exp[i*GW +: GW] = m_mask[i] ? grad_in_0[i] : '0;
        exp_q.push_back(m_exp);
        m_gv = 1'b1;
      end else if (m_gv && grad_out_0_ready) begin
        m_gv = 1'b0;
      end
      if (m_fwd) begin
        for (int i = 0; i < N; i++) begin
          int x;
          x = $signed(data_in_0[i]);
          m_mask[i] = (x > MINV) && (x < MAXV);
        end
        mask_q.push_back(m_mask);
      end
    end
  end

  // Monitor: compares handshakes and data away from the active edge.
  always @(negedge clk) begin
    int cnt;
    cnt = mask_q.size();
    check("mask_count", int'(mask_count), cnt);
    check("data_in_0_ready", int'(data_in_0_ready), int'(data_out_0_ready && (rst || cnt < D)));
    check("data_out_0_valid", int'(data_out_0_valid), int'(data_in_0_valid && (rst || cnt < D)));
    check("grad_in_0_ready", int'(grad_in_0_ready), int'(!rst && cnt > 0 && (!m_gv || grad_out_0_ready)));
    check("grad_out_0_valid", int'(grad_out_0_valid), int'(m_gv));
    if (data_out_0_valid)
      for (int i = 0; i < N; i++)
        check("data_out_lane", int'($signed(data_out_0[i])), clamp_ref(int'($signed(data_in_0[i]))));
    if (grad_out_0_valid) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL grad_out_unexpected: valid output with no gradient accepted (t=%0t)", $time);
      end else begin
        for (int i = 0; i < N; i++)
          check("grad_out_lane", int'(grad_out_0[i]), int'(exp_q[0][i*GW +: GW]));
        if (grad_out_0_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_din(input int a, input int b, input int c, input int d);
    data_in_0[0] = W'(a); data_in_0[1] = W'(b); data_in_0[2] = W'(c); data_in_0[3] = W'(d);
  endtask

  task automatic rand_din();
    int picks [6];
    picks = '{-65, -64, -63, 62, 63, 64};
    for (int i = 0; i < N; i++)
      data_in_0[i] = ($urandom_range(0, 2) == 0) ? W'(picks[$urandom_range(0, 5)]) : W'($urandom);
  endtask

  task automatic rand_gin();
    for (int i = 0; i < N; i++) grad_in_0[i] = GW'($urandom);
  endtask

  initial begin
    set_din(0, 0, 0, 0);
    for (int i = 0; i < N; i++) grad_in_0[i] = '0;
    data_in_0_valid  = 1'b0;
    data_out_0_ready = 1'b1;
    grad_in_0_valid  = 1'b0;
    grad_out_0_ready = 1'b1;
    rst              = 1'b1;
    step(3);
    rst = 1'b0;
    for (int i = 0; i < N; i++) check("reset_grad_out", int'(grad_out_0[i]), 0);

    // Mixed-range forward vector, then its gradient.
    set_din(-100, -64, 10, 63);
    data_in_0_valid = 1'b1;
    step(1);
    data_in_0_valid = 1'b0;
    grad_in_0[0] = 8'd5; grad_in_0[1] = 8'd6; grad_in_0[2] = 8'd7; grad_in_0[3] = 8'd8;
    grad_in_0_valid = 1'b1;
    step(1);
    grad_in_0_valid = 1'b0;
    step(2);

    // Fill to full, pop once while still pushing, then drain.
    data_in_0_valid = 1'b1;
    for (int k = 0; k < D + 2; k++) begin rand_din(); step(1); end
    rand_gin();
    grad_in_0_valid = 1'b1;
    step(1);
    grad_in_0_valid = 1'b0;
    step(3);
    data_in_0_valid = 1'b0;
    grad_in_0_valid = 1'b1;
    for (int k = 0; k < D + 4; k++) begin rand_gin(); step(1); end

    // Gradient waiting on an empty FIFO, released by a single push.
    step(3);
    rand_din();
    data_in_0_valid = 1'b1;
    step(1);
    data_in_0_valid = 1'b0;
    step(3);
    grad_in_0_valid = 1'b0;

    // Output backpressure for 5 cycles, then streaming across a pointer wrap.
    data_in_0_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin rand_din(); step(1); end
    data_in_0_valid  = 1'b0;
    grad_out_0_ready = 1'b0;
    grad_in_0_valid  = 1'b1;
    rand_gin();
    step(5);
    grad_out_0_ready = 1'b1;
    data_in_0_valid  = 1'b1;
    for (int k = 0; k < 20; k++) begin rand_din(); rand_gin(); step(1); end
    data_in_0_valid = 1'b0;
    step(D);
    grad_in_0_valid = 1'b0;
    step(2);

    // Mid-stream reset with masks queued and an output pending.
    data_in_0_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin rand_din(); step(1); end
    data_in_0_valid  = 1'b0;
    grad_out_0_ready = 1'b0;
    grad_in_0_valid  = 1'b1;
    step(1);
    grad_in_0_valid  = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    grad_out_0_ready = 1'b1;
    check("post_reset_count", int'(mask_count), 0);
    check("post_reset_gvalid", int'(grad_out_0_valid), 0);
    set_din(-100, -64, 10, 63);
    data_in_0_valid = 1'b1;
    step(1);
    data_in_0_valid = 1'b0;
    grad_in_0_valid = 1'b1;
    step(1);
    grad_in_0_valid = 1'b0;
    step(2);

    // Randomised traffic with occasional resets.
    for (int k = 0; k < 2000; k++) begin
      rand_din();
      rand_gin();
      data_in_0_valid  = ($urandom_range(0, 3) != 0);
      data_out_0_ready = ($urandom_range(0, 4) != 0);
      grad_in_0_valid  = ($urandom_range(0, 2) != 0);
      grad_out_0_ready = ($urandom_range(0, 3) != 0);
      rst              = ($urandom_range(0, 299) == 0);
      step(1);
    end

    rst              = 1'b0;
    data_in_0_valid  = 1'b0;
    grad_in_0_valid  = 1'b0;
    data_out_0_ready = 1'b1;
    grad_out_0_ready = 1'b1;
    step(4);
    check("drained_scoreboard", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
